// File: rtl/readout_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : readout_data_arbiter
// Description : Merges TLU trigger words and front-end data words into one
//               32-bit output stream. TLU words win arbitration, but after
//               MAX_TLU_BURST consecutive TLU grants with FE data waiting,
//               one FE word is forced through. Also produces the NEAR_FULL
//               back-pressure flag returned to the TLU controller.
// Revision    : 1.0 - initial release
// ============================================================================
module readout_data_arbiter #(
    parameter int MAX_TLU_BURST    = 4,   // 1..15
    parameter int NEAR_FULL_CYCLES = 8    // 1..255
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,

    input  logic        TLU_FIFO_EMPTY,
    input  logic [31:0] TLU_FIFO_DATA,
    output logic        TLU_FIFO_READ,

    input  logic        FE_FIFO_EMPTY,
    input  logic [31:0] FE_FIFO_DATA,
    output logic        FE_FIFO_READ,

    input  logic        OUT_FULL,
    output logic        OUT_WRITE,
    output logic [31:0] OUT_DATA,

    output logic        NEAR_FULL,
    output logic [15:0] TLU_WORD_CNT,
    output logic [15:0] FE_WORD_CNT
);

    localparam logic [3:0] c_max_burst        = 4'(MAX_TLU_BURST);
    localparam logic [7:0] c_near_full_cycles = 8'(NEAR_FULL_CYCLES);
    localparam logic       c_tag_tlu          = 1'b1;
    localparam logic       c_tag_fe           = 1'b0;

    // Output holding register and its source tag
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_tag;

    // Arbitration and back-pressure state
    logic [3:0]  r_burst_cnt;
    logic [7:0]  r_full_cnt;
    logic        r_near_full;

    // Statistics
    logic [15:0] r_tlu_word_cnt;
    logic [15:0] r_fe_word_cnt;

    // Combinational decisions
    logic        w_out_write;
    logic        w_load;
    logic        w_grant_tlu;
    logic        w_grant_fe;
    logic [3:0]  w_burst_nxt;
    logic [7:0]  w_full_cnt_nxt;

    // The held word leaves whenever downstream has room; the register may
    // refill in the same cycle, giving one word per cycle when streaming.
    assign w_out_write = r_out_valid & ~OUT_FULL;
    assign w_load      = ~r_out_valid | w_out_write;

    // Source selection: TLU first, FE forced after a full TLU burst
    always_comb begin
        w_grant_tlu = 1'b0;
        w_grant_fe  = 1'b0;
        w_burst_nxt = r_burst_cnt;
        if (w_load) begin
            unique case ({~TLU_FIFO_EMPTY, ~FE_FIFO_EMPTY})
                2'b10: begin
                    // FE idle: the burst count is left alone on purpose
                    w_grant_tlu = 1'b1;
                end
                2'b01: begin
                    w_grant_fe  = 1'b1;
                    w_burst_nxt = 4'd0;
                end
                2'b11: begin
                    if (r_burst_cnt < c_max_burst) begin
                        w_grant_tlu = 1'b1;
                        w_burst_nxt = r_burst_cnt + 4'd1;
                    end else begin
                        w_grant_fe  = 1'b1;
                        w_burst_nxt = 4'd0;
                    end
                end
                default: begin
                    w_grant_tlu = 1'b0;
                    w_grant_fe  = 1'b0;
                end
            endcase
        end
    end

    // Reads are masked by reset so nothing is popped while the block is held
    assign TLU_FIFO_READ = w_grant_tlu & BUS_RST_N;
    assign FE_FIFO_READ  = w_grant_fe  & BUS_RST_N;

    // Output register: capture the granted word or empty out after a write
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_tag   <= c_tag_fe;
        end else if (w_grant_tlu) begin
            r_out_valid <= 1'b1;
            r_out_data  <= TLU_FIFO_DATA;
            r_out_tag   <= c_tag_tlu;
        end else if (w_grant_fe) begin
            r_out_valid <= 1'b1;
            r_out_data  <= FE_FIFO_DATA;
            r_out_tag   <= c_tag_fe;
        end else if (w_out_write) begin
            r_out_valid <= 1'b0;
        end
    end

    // Burst counter only moves on a load decision, so it freezes in a stall
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_burst_cnt <= 4'd0;
        end else begin
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Word counters advance on the word actually leaving, by its source tag
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_tlu_word_cnt <= 16'd0;
            r_fe_word_cnt  <= 16'd0;
        end else if (w_out_write) begin
            if (r_out_tag == c_tag_tlu) begin
                r_tlu_word_cnt <= r_tlu_word_cnt + 16'd1;
            end else begin
                r_fe_word_cnt  <= r_fe_word_cnt + 16'd1;
            end
        end
    end

    // Saturating count of consecutive full cycles; any free cycle restarts it
    always_comb begin
        w_full_cnt_nxt = 8'd0;
        if (OUT_FULL) begin
            if (r_full_cnt >= c_near_full_cycles) begin
                w_full_cnt_nxt = c_near_full_cycles;
            end else begin
                w_full_cnt_nxt = r_full_cnt + 8'd1;
            end
        end
    end

    // Full counter and registered NEAR_FULL flag follow the same edge, so
    // the flag rises on the Nth full cycle and drops on the first free one
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_full_cnt  <= 8'd0;
            r_near_full <= 1'b0;
        end else begin
            r_full_cnt  <= w_full_cnt_nxt;
            r_near_full <= (w_full_cnt_nxt == c_near_full_cycles);
        end
    end

    assign OUT_WRITE    = w_out_write;
    assign OUT_DATA     = r_out_data;
    assign NEAR_FULL    = r_near_full;
    assign TLU_WORD_CNT = r_tlu_word_cnt;
    assign FE_WORD_CNT  = r_fe_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_readout_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_readout_data_arbiter
// Description : Directed self-checking bench for readout_data_arbiter with
//               first-word-fall-through FIFO models on both inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_data_arbiter;

    logic        BUS_CLK;
    logic        BUS_RST_N;
    logic        TLU_FIFO_EMPTY;
    logic [31:0] TLU_FIFO_DATA;
    logic        TLU_FIFO_READ;
    logic        FE_FIFO_EMPTY;
    logic [31:0] FE_FIFO_DATA;
    logic        FE_FIFO_READ;
    logic        OUT_FULL;
    logic        OUT_WRITE;
    logic [31:0] OUT_DATA;
    logic        NEAR_FULL;
    logic [15:0] TLU_WORD_CNT;
    logic [15:0] FE_WORD_CNT;

    readout_data_arbiter #(
        .MAX_TLU_BURST    (4),
        .NEAR_FULL_CYCLES (8)
    ) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST_N      (BUS_RST_N),
        .TLU_FIFO_EMPTY (TLU_FIFO_EMPTY),
        .TLU_FIFO_DATA  (TLU_FIFO_DATA),
        .TLU_FIFO_READ  (TLU_FIFO_READ),
        .FE_FIFO_EMPTY  (FE_FIFO_EMPTY),
        .FE_FIFO_DATA   (FE_FIFO_DATA),
        .FE_FIFO_READ   (FE_FIFO_READ),
        .OUT_FULL       (OUT_FULL),
        .OUT_WRITE      (OUT_WRITE),
        .OUT_DATA       (OUT_DATA),
        .NEAR_FULL      (NEAR_FULL),
        .TLU_WORD_CNT   (TLU_WORD_CNT),
        .FE_WORD_CNT    (FE_WORD_CNT)
    );

    // 100 MHz clock
    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          wr_total = 0;
    logic        log_en   = 1'b1;
    logic        fe_rd_seen;
    logic        cap_rt, cap_rf, cap_w;
    logic [31:0] tq[$];
    logic [31:0] fq[$];
    logic [31:0] out_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present the FIFO heads the way a first-word-fall-through FIFO does
    task automatic drive_fifos();
        TLU_FIFO_EMPTY = (tq.size() == 0);
        TLU_FIFO_DATA  = (tq.size() == 0) ? 32'd0 : tq[0];
        FE_FIFO_EMPTY  = (fq.size() == 0);
        FE_FIFO_DATA   = (fq.size() == 0) ? 32'd0 : fq[0];
    endtask

    // One clock: sample pre-edge, apply pops after the edge, then settle
    task automatic tick();
        #1;
        cap_rt = TLU_FIFO_READ;
        cap_rf = FE_FIFO_READ;
        cap_w  = OUT_WRITE;
        check("read_exclusive", {31'd0, cap_rt & cap_rf}, 32'd0);
        check("tlu_read_empty", {31'd0, cap_rt & (tq.size() == 0)}, 32'd0);
        check("fe_read_empty",  {31'd0, cap_rf & (fq.size() == 0)}, 32'd0);
        if (cap_rf) fe_rd_seen = 1'b1;
        if (cap_w) begin
            wr_total++;
            if (log_en) out_log.push_back(OUT_DATA);
        end
        @(posedge BUS_CLK);
        #1;
        if (cap_rt) void'(tq.pop_front());
        if (cap_rf) void'(fq.pop_front());
        drive_fifos();
        #1;
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (wr_total < target && n < budget) begin
            tick();
            n++;
        end
        check("run_until_in_budget", {31'd0, wr_total >= target}, 32'd1);
    endtask

    task automatic do_reset();
        #3 BUS_RST_N = 1'b0;
        @(posedge BUS_CLK);
        #1 BUS_RST_N = 1'b1;
        #1;
    endtask

    initial begin
        logic [19:0] order;
        logic [31:0] held;
        int          ti, fi, base;

        BUS_RST_N = 1'b0;
        OUT_FULL  = 1'b0;
        drive_fifos();
        fe_rd_seen = 1'b0;

        // ---- Reset state ----
        repeat (2) @(posedge BUS_CLK);
        #2;
        check("rst_out_write", {31'd0, OUT_WRITE}, 32'd0);
        check("rst_out_data",  OUT_DATA, 32'd0);
        check("rst_near_full", {31'd0, NEAR_FULL}, 32'd0);
        check("rst_tlu_cnt",   {16'd0, TLU_WORD_CNT}, 32'd0);
        check("rst_fe_cnt",    {16'd0, FE_WORD_CNT}, 32'd0);
        BUS_RST_N = 1'b1;
        @(posedge BUS_CLK);
        #2;

        // ---- 1: two TLU words, FE empty ----
        tq.push_back(32'h8000_0001);
        tq.push_back(32'h8000_0002);
        drive_fifos();
        #1;
        check("t1_first_read",   {31'd0, TLU_FIFO_READ}, 32'd1);
        check("t1_no_write_yet", {31'd0, OUT_WRITE}, 32'd0);
        tick();
        check("t1_w0_write", {31'd0, OUT_WRITE}, 32'd1);
        check("t1_w0_data",  OUT_DATA, 32'h8000_0001);
        tick();
        check("t1_w1_write", {31'd0, OUT_WRITE}, 32'd1);
        check("t1_w1_data",  OUT_DATA, 32'h8000_0002);
        tick();
        check("t1_idle_write", {31'd0, OUT_WRITE}, 32'd0);
        check("t1_tlu_cnt",    {16'd0, TLU_WORD_CNT}, 32'd2);
        check("t1_fe_cnt",     {16'd0, FE_WORD_CNT}, 32'd0);
        check("t1_fe_never_read", {31'd0, fe_rd_seen}, 32'd0);

        // ---- 2: burst fairness, 10 + 10 words ----
        do_reset();
        out_log.delete();
        for (int i = 0; i < 10; i++) begin
            tq.push_back(32'hA000_0000 + i);
            fq.push_back(32'hB000_0000 + i);
        end
        drive_fifos();
        run_until(wr_total + 20, 60);
        order = 20'b1111_0111_1011_0000_0000;   // 1 = TLU, MSB first
        ti = 0;
        fi = 0;
        check("t2_word_count", out_log.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (order[19 - i]) begin
                check($sformatf("t2_word%0d", i),
                      (i < out_log.size()) ? out_log[i] : 32'hDEAD_DEAD, 32'hA000_0000 + ti);
                ti++;
            end else begin
                check($sformatf("t2_word%0d", i),
                      (i < out_log.size()) ? out_log[i] : 32'hDEAD_DEAD, 32'hB000_0000 + fi);
                fi++;
            end
        end
        check("t2_tlu_cnt", {16'd0, TLU_WORD_CNT}, 32'd10);
        check("t2_fe_cnt",  {16'd0, FE_WORD_CNT}, 32'd10);

        // ---- 3: 3-cycle stall mid-stream ----
        out_log.delete();
        base = wr_total;
        for (int i = 0; i < 6; i++) tq.push_back(32'hC000_0000 + i);
        drive_fifos();
        tick();
        tick();
        OUT_FULL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_stall_no_tlu_read", {31'd0, cap_rt}, 32'd0);
            check("t3_stall_no_write",    {31'd0, cap_w}, 32'd0);
            check("t3_stall_data",        OUT_DATA, 32'hC000_0001);
            check("t3_stall_tlu_cnt",     {16'd0, TLU_WORD_CNT}, 32'd11);
            check("t3_stall_near_full",   {31'd0, NEAR_FULL}, 32'd0);
        end
        OUT_FULL = 1'b0;
        run_until(base + 6, 30);
        check("t3_word_count", out_log.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_word%0d", i),
                  (i < out_log.size()) ? out_log[i] : 32'hDEAD_DEAD, 32'hC000_0000 + i);
        end
        check("t3_tlu_cnt",   {16'd0, TLU_WORD_CNT}, 32'd16);
        check("t3_near_full", {31'd0, NEAR_FULL}, 32'd0);

        // ---- 4: NEAR_FULL after 8 full cycles ----
        tick();
        OUT_FULL = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("t4_near_full_c%0d", i), {31'd0, NEAR_FULL}, (i >= 8) ? 32'd1 : 32'd0);
        end
        OUT_FULL = 1'b0;
        tick();
        check("t4_near_full_drop", {31'd0, NEAR_FULL}, 32'd0);

        // ---- 5: async reset pulse while a word is held ----
        out_log.delete();
        fq.push_back(32'hD000_0001);
        fq.push_back(32'hD000_0002);
        drive_fifos();
        tick();
        OUT_FULL = 1'b1;
        tick();
        check("t5_held_data", OUT_DATA, 32'hD000_0001);
        #1 BUS_RST_N = 1'b0;
        #1;
        check("t5_rst_data",      OUT_DATA, 32'd0);
        check("t5_rst_write",     {31'd0, OUT_WRITE}, 32'd0);
        check("t5_rst_tlu_cnt",   {16'd0, TLU_WORD_CNT}, 32'd0);
        check("t5_rst_fe_cnt",    {16'd0, FE_WORD_CNT}, 32'd0);
        check("t5_rst_fe_read",   {31'd0, FE_FIFO_READ}, 32'd0);
        check("t5_rst_near_full", {31'd0, NEAR_FULL}, 32'd0);
        #1 BUS_RST_N = 1'b1;
        OUT_FULL = 1'b0;
        run_until(wr_total + 1, 10);
        tick();
        check("t5_after_word",   (out_log.size() > 0) ? out_log[0] : 32'hDEAD_DEAD, 32'hD000_0002);
        check("t5_after_count",  out_log.size(), 32'd1);
        check("t5_after_fe_cnt", {16'd0, FE_WORD_CNT}, 32'd1);

        // ---- 6: FE counter wrap ----
        do_reset();
        log_en = 1'b0;
        for (int i = 0; i < 65536; i++) fq.push_back(i);
        drive_fifos();
        run_until(wr_total + 65536, 70000);
        check("t6_fe_cnt_wrap", {16'd0, FE_WORD_CNT}, 32'd0);
        check("t6_tlu_cnt",     {16'd0, TLU_WORD_CNT}, 32'd0);
        log_en = 1'b1;
        out_log.delete();
        fq.push_back(32'h1234_5678);
        drive_fifos();
        run_until(wr_total + 1, 10);
        check("t6_fe_cnt_after", {16'd0, FE_WORD_CNT}, 32'd1);
        check("t6_last_word", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_DEAD, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
